// File: rtl/shift_issue_stage_if.sv
// Request/response handshake bundle for shift_issue_stage.
// master = producer/consumer side, slave = the issue stage itself.
interface shift_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [4:0]  in_b;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_neg;
    logic        out_illegal;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_neg, out_illegal
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_neg, out_illegal
    );
endinterface

// File: rtl/shift_issue_stage.sv
// Shift issue stage: one issue register feeding a shifter, results queued in
// a 2-entry FIFO with zero/negative/illegal flags and a pop counter.

module shifter (
    output logic [31:0] out,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ctl0,
    input  logic        ctl1
);
    // NOTE: every output of an always_comb gets a value on every path (default arm) so no latch is inferred.
    always_comb begin
        case ({ctl1, ctl0})
            2'b01:   out = a << b;
            2'b10:   out = $unsigned($signed(a) >>> b);
            2'b11:   out = a >> b;
            default: out = a;
        endcase
    end
endmodule

module shift_issue_stage #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_issue_stage_if.slave  bus,
    output logic [15:0]         op_count
);
    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        neg;
        logic        illegal;
    } entry_t;

    logic        s1_valid;
    logic [31:0] s1_a;
    logic [4:0]  s1_b;
    logic [1:0]  s1_op;

    logic [31:0] shift_out;
    entry_t      push_entry;
    entry_t      head;
    entry_t      fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    logic        out_valid;
    logic        pop;
    logic        advance;
    logic        accept;

    shifter u_shifter (
        .out  (shift_out),
        .a    (s1_a),
        .b    ({27'd0, s1_b}),
        .ctl0 (s1_op[0]),
        .ctl1 (s1_op[1])
    );

    assign push_entry.result  = shift_out;
    assign push_entry.zero    = (shift_out == 32'd0);
    assign push_entry.neg     = shift_out[31];
    assign push_entry.illegal = (s1_op == 2'b00);

    // A full FIFO still takes a push when the head is leaving in the same cycle.
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && bus.out_ready;
    assign advance   = s1_valid && ((count < 2'(FIFO_DEPTH)) || pop);
    assign accept    = bus.in_valid && bus.in_ready;

    assign bus.in_ready = !s1_valid || advance;

    assign head            = fifo_mem[rd_ptr];
    assign bus.out_valid   = out_valid;
    assign bus.out_result  = out_valid ? head.result  : 32'd0;
    assign bus.out_zero    = out_valid ? head.zero    : 1'b0;
    assign bus.out_neg     = out_valid ? head.neg     : 1'b0;
    assign bus.out_illegal = out_valid ? head.illegal : 1'b0;

    // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            op_count <= 16'd0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end
            if (advance) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                op_count <= op_count + 16'd1;
            end
            if (advance && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !advance) begin
                count <= count - 2'd1;
            end
        end
    end

    // NOTE: payload and FIFO storage carry no reset; the valid bit and count qualify them, and outputs are gated to 0 when empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a  <= bus.in_a;
            s1_b  <= bus.in_b;
            s1_op <= bus.in_op;
        end
        if (advance) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end
endmodule
